// File: rtl/mem_pkg.sv
// mem_pkg: shared constants and types for the memory arbiter slice.
//   AW, DW  : default address / data width of the 64K x 128 memory
//   TAG_IW  : tag index width, wide enough for up to 8 requesters
//   state_t : arbiter FSM state
//   tag_t   : in-flight read tag (owning requester index plus valid)
package mem_pkg;

   localparam int AW     = 16;
   localparam int DW     = 128;
   localparam int TAG_IW = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   typedef struct packed {
      logic              valid;
      logic [TAG_IW-1:0] idx;
   } tag_t;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: rotated priority scan. Starting at index `start` and wrapping
// modulo N, returns the first and second set bits of `vec`.
//   vec          in  N   candidate mask
//   start        in  IW  index scanned first
//   first_idx    out IW  first set index in scan order
//   first_found  out 1   first_idx is valid
//   second_idx   out IW  second set index in scan order
//   second_found out 1   second_idx is valid
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  vec,
   input  logic [IW-1:0] start,
   output logic [IW-1:0] first_idx,
   output logic          first_found,
   output logic [IW-1:0] second_idx,
   output logic          second_found
);

   logic [IW-1:0] j;

   always_comb begin
      first_idx    = '0;
      first_found  = 1'b0;
      second_idx   = '0;
      second_found = 1'b0;
      j            = '0;
      for (int k = 0; k < N; k++) begin
         j = IW'((int'(start) + k) % N);
         if (vec[j]) begin
            if (!first_found) begin
               first_found = 1'b1;
               first_idx   = j;
            end else if (!second_found) begin
               second_found = 1'b1;
               second_idx   = j;
            end
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin front end for a 1W/2R memory, plus a zero-fill
// sequencer.
//   clock, reset              clock / synchronous active-high reset
//   req, req_we               per-requester valid and write select
//   req_addr, req_wdata       packed per-requester address / write data
//   gnt                       combinational accept (transfer on req&gnt)
//   rvalid, rdata             per-requester read return, 2 edges after accept
//   clear_start, busy         zero-fill command / in-progress flag
//   mem_we, mem_waddr,
//   mem_wbus                  registered memory write port
//   mem_raddr1, mem_raddr2    registered memory read addresses
//   mem_rbus1, mem_rbus2      memory read data (combinational in memory)
//
// state | meaning
// IDLE  | arbitrate requesters, one write + two reads per cycle
// CLEAR | write zero to clr_addr each cycle, no grants
module mem_arbiter #(
   parameter int NREQ        = 4,
   parameter int AW          = mem_pkg::AW,
   parameter int DW          = mem_pkg::DW,
   parameter int CLEAR_DEPTH = 65536
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   req_we,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   rvalid,
   output logic [NREQ*DW-1:0] rdata,
   input  logic              clear_start,
   output logic              busy,
   output logic              mem_we,
   output logic [AW-1:0]     mem_waddr,
   output logic [DW-1:0]     mem_wbus,
   output logic [AW-1:0]     mem_raddr1,
   output logic [AW-1:0]     mem_raddr2,
   input  logic [DW-1:0]     mem_rbus1,
   input  logic [DW-1:0]     mem_rbus2
);

   import mem_pkg::*;

   localparam int IW = $clog2(NREQ);
   localparam logic [AW-1:0] CLR_LAST = AW'(CLEAR_DEPTH - 1);

   state_t        state;
   logic [AW-1:0] clr_addr;
   logic [IW-1:0] rr;
   tag_t          tag1;
   tag_t          tag2;

   logic [NREQ-1:0] wr_mask;
   logic [NREQ-1:0] rd_mask;
   logic [IW-1:0]   w_idx;
   logic            w_found;
   logic [IW-1:0]   unused_w2_idx;
   logic            unused_w2_found;
   logic [IW-1:0]   r1_idx;
   logic            r1_found;
   logic [IW-1:0]   r2_idx;
   logic            r2_found;

   logic            arb_en;
   logic            w_go;
   logic            r1_go;
   logic            r2_go;
   logic [IW-1:0]   last_idx;
   logic [IW-1:0]   rr_next;
   logic [IW-1:0]   j;

   assign wr_mask = req & req_we;
   assign rd_mask = req & ~req_we;

   rr_pick #(.N(NREQ), .IW(IW)) u_pick_wr (
      .vec          (wr_mask),
      .start        (rr),
      .first_idx    (w_idx),
      .first_found  (w_found),
      .second_idx   (unused_w2_idx),
      .second_found (unused_w2_found)
   );

   rr_pick #(.N(NREQ), .IW(IW)) u_pick_rd (
      .vec          (rd_mask),
      .start        (rr),
      .first_idx    (r1_idx),
      .first_found  (r1_found),
      .second_idx   (r2_idx),
      .second_found (r2_found)
   );

   // A clear command takes the cycle away from the requesters.
   assign arb_en = (state == IDLE) && !clear_start && !reset;
   assign w_go   = arb_en && w_found;
   assign r1_go  = arb_en && r1_found;
   assign r2_go  = arb_en && r2_found;

   always_comb begin
      gnt = '0;
      if (w_go)  gnt[w_idx]  = 1'b1;
      if (r1_go) gnt[r1_idx] = 1'b1;
      if (r2_go) gnt[r2_idx] = 1'b1;
   end

   // Pointer moves just past the last granted requester in scan order.
   always_comb begin
      last_idx = rr;
      j        = '0;
      for (int k = 0; k < NREQ; k++) begin
         j = IW'((int'(rr) + k) % NREQ);
         if (gnt[j]) last_idx = j;
      end
      rr_next = IW'((int'(last_idx) + 1) % NREQ);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         busy       <= 1'b0;
         clr_addr   <= '0;
         rr         <= '0;
         mem_we     <= 1'b0;
         mem_waddr  <= '0;
         mem_wbus   <= '0;
         mem_raddr1 <= '0;
         mem_raddr2 <= '0;
         tag1       <= '0;
         tag2       <= '0;
      end else begin
         case (state)
            IDLE: begin
               mem_we <= w_go;
               if (w_go) begin
                  mem_waddr <= req_addr[w_idx*AW +: AW];
                  mem_wbus  <= req_wdata[w_idx*DW +: DW];
               end
               // An unused read port keeps its previous address.
               if (r1_go) mem_raddr1 <= req_addr[r1_idx*AW +: AW];
               if (r2_go) mem_raddr2 <= req_addr[r2_idx*AW +: AW];
               tag1.valid <= r1_go;
               tag1.idx   <= TAG_IW'(r1_idx);
               tag2.valid <= r2_go;
               tag2.idx   <= TAG_IW'(r2_idx);
               if (|gnt) rr <= rr_next;
               if (clear_start) begin
                  state    <= CLEAR;
                  busy     <= 1'b1;
                  clr_addr <= '0;
               end
            end
            CLEAR: begin
               mem_we    <= 1'b1;
               mem_waddr <= clr_addr;
               mem_wbus  <= '0;
               tag1      <= '0;
               tag2      <= '0;
               clr_addr  <= clr_addr + AW'(1);
               if (clr_addr == CLR_LAST) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Return path: memory read is combinational from the registered address,
   // so data is captured one edge after the accept edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         rvalid <= '0;
         rdata  <= '0;
      end else begin
         rvalid <= '0;
         for (int i = 0; i < NREQ; i++) begin
            if (tag1.valid && tag1.idx == TAG_IW'(i)) begin
               rvalid[i]          <= 1'b1;
               rdata[i*DW +: DW]  <= mem_rbus1;
            end else if (tag2.valid && tag2.idx == TAG_IW'(i)) begin
               rvalid[i]          <= 1'b1;
               rdata[i*DW +: DW]  <= mem_rbus2;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   localparam int NREQ = 4;
   localparam int AW   = 16;
   localparam int DW   = 128;
   localparam int CD   = 16;

   logic                clock;
   logic                reset;
   logic [NREQ-1:0]     req;
   logic [NREQ-1:0]     req_we;
   logic [NREQ*AW-1:0]  req_addr;
   logic [NREQ*DW-1:0]  req_wdata;
   logic [NREQ-1:0]     gnt;
   logic [NREQ-1:0]     rvalid;
   logic [NREQ*DW-1:0]  rdata;
   logic                clear_start;
   logic                busy;
   logic                mem_we;
   logic [AW-1:0]       mem_waddr;
   logic [DW-1:0]       mem_wbus;
   logic [AW-1:0]       mem_raddr1;
   logic [AW-1:0]       mem_raddr2;
   logic [DW-1:0]       mem_rbus1;
   logic [DW-1:0]       mem_rbus2;

   mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CLEAR_DEPTH(CD)) dut (
      .clock       (clock),
      .reset       (reset),
      .req         (req),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .gnt         (gnt),
      .rvalid      (rvalid),
      .rdata       (rdata),
      .clear_start (clear_start),
      .busy        (busy),
      .mem_we      (mem_we),
      .mem_waddr   (mem_waddr),
      .mem_wbus    (mem_wbus),
      .mem_raddr1  (mem_raddr1),
      .mem_raddr2  (mem_raddr2),
      .mem_rbus1   (mem_rbus1),
      .mem_rbus2   (mem_rbus2)
   );

   // Memory model: registered write, combinational read.
   logic [DW-1:0] mem [0:65535];
   always @(posedge clock) if (mem_we) mem[mem_waddr] <= mem_wbus;
   assign mem_rbus1 = mem[mem_raddr1];
   assign mem_rbus2 = mem[mem_raddr2];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_tot  = 0;
   int n_pass = 0;

   typedef struct packed {
      logic [3:0] req;
      logic [3:0] we;
      logic [3:0] gnt;
   } vec_t;

   vec_t tbl [14];

   task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_tot++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
   endtask

   task automatic preload(input int a, input logic [DW-1:0] v);
      mem[a] <= v;
   endtask

   task automatic set_port(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_addr[i*AW +: AW]  = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1; req = '0; req_we = '0; clear_start = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_cnt;
      int zero_cnt;
      int viol;
      logic [3:0] g [6];

      tbl[0]  = '{req: 4'b1111, we: 4'b0000, gnt: 4'b0011};
      tbl[1]  = '{req: 4'b1111, we: 4'b0000, gnt: 4'b1100};
      tbl[2]  = '{req: 4'b1111, we: 4'b0000, gnt: 4'b0011};
      tbl[3]  = '{req: 4'b1111, we: 4'b0000, gnt: 4'b1100};
      tbl[4]  = '{req: 4'b1111, we: 4'b0011, gnt: 4'b1101};
      tbl[5]  = '{req: 4'b1110, we: 4'b0011, gnt: 4'b1110};
      tbl[6]  = '{req: 4'b0000, we: 4'b0000, gnt: 4'b0000};
      tbl[7]  = '{req: 4'b0010, we: 4'b0010, gnt: 4'b0010};
      tbl[8]  = '{req: 4'b1111, we: 4'b1111, gnt: 4'b0100};
      tbl[9]  = '{req: 4'b1111, we: 4'b1111, gnt: 4'b1000};
      tbl[10] = '{req: 4'b0101, we: 4'b0000, gnt: 4'b0101};
      tbl[11] = '{req: 4'b1011, we: 4'b0001, gnt: 4'b1011};
      tbl[12] = '{req: 4'b0011, we: 4'b0000, gnt: 4'b0011};
      tbl[13] = '{req: 4'b1111, we: 4'b0000, gnt: 4'b1100};

      reset = 1'b1; req = 4'b1111; req_we = '0; clear_start = 1'b0;
      req_addr = '0; req_wdata = '0;
      for (int i = 0; i < NREQ; i++) set_port(i, AW'(16'h0100 + i), DW'(i + 1));

      // Reset state (requests held during reset must not be granted)
      @(negedge clock);
      @(negedge clock);
      #1;
      chk("rst_gnt",    DW'(gnt),        '0);
      chk("rst_mem_we", DW'(mem_we),     '0);
      chk("rst_waddr",  DW'(mem_waddr),  '0);
      chk("rst_wbus",   mem_wbus,        '0);
      chk("rst_raddr1", DW'(mem_raddr1), '0);
      chk("rst_raddr2", DW'(mem_raddr2), '0);
      chk("rst_rvalid", DW'(rvalid),     '0);
      chk("rst_rdata",  DW'(|rdata),     '0);
      chk("rst_busy",   DW'(busy),       '0);
      req = '0;
      reset = 1'b0;

      // Arbitration table, rr starts at 0
      for (int k = 0; k < 14; k++) begin
         @(negedge clock);
         req = tbl[k].req; req_we = tbl[k].we;
         #1;
         chk($sformatf("tbl%0d_gnt", k), DW'(gnt), DW'(tbl[k].gnt));
      end

      // Single read: requester 2 reads 0x10
      do_reset();
      preload(16'h0010, {16{8'hA5}});
      @(negedge clock);
      req = 4'b0100; req_we = '0; set_port(2, 16'h0010, '0);
      #1; chk("rd1_gnt", DW'(gnt), DW'(4'b0100));
      @(negedge clock);
      req = '0;
      #1; chk("rd1_rvalid_c1", DW'(rvalid), '0);
      chk("rd1_raddr1", DW'(mem_raddr1), DW'(16'h0010));
      @(negedge clock); #1;
      chk("rd1_rvalid_c2", DW'(rvalid), DW'(4'b0100));
      chk("rd1_rdata", rdata[2*DW +: DW], {16{8'hA5}});
      @(negedge clock); #1;
      chk("rd1_rvalid_c3", DW'(rvalid), '0);
      chk("rd1_rdata_hold", rdata[2*DW +: DW], {16{8'hA5}});

      // Write then read on the next cycle returns new data
      do_reset();
      preload(16'h0020, DW'(32'hDEAD));
      preload(16'h0030, DW'(32'hBEEF));
      @(negedge clock);
      req = 4'b0001; req_we = 4'b0001; set_port(0, 16'h0020, DW'(32'h1234));
      #1; chk("wr_gnt", DW'(gnt), DW'(4'b0001));
      @(negedge clock);
      req = 4'b0001; req_we = 4'b0000;
      #1; chk("wr_rd_gnt", DW'(gnt), DW'(4'b0001));
      @(negedge clock);
      req = '0;
      @(negedge clock); #1;
      chk("wr_rd_rvalid", DW'(rvalid), DW'(4'b0001));
      chk("wr_rd_rdata", rdata[0 +: DW], DW'(32'h1234));

      // Same-edge read and write to one address returns old data
      @(negedge clock);
      req = 4'b0011; req_we = 4'b0001;
      set_port(0, 16'h0030, DW'(32'h5678));
      set_port(1, 16'h0030, '0);
      #1; chk("haz_gnt", DW'(gnt), DW'(4'b0011));
      @(negedge clock);
      req = '0; req_we = '0;
      @(negedge clock); #1;
      chk("haz_rvalid", DW'(rvalid), DW'(4'b0010));
      chk("haz_rdata_old", rdata[DW +: DW], DW'(32'hBEEF));
      chk("haz_mem_new", mem[16'h0030], DW'(32'h5678));

      // Reset while a read is in flight drops it
      @(negedge clock);
      req = 4'b0100; req_we = '0; set_port(2, 16'h0010, '0);
      #1; chk("rstrd_gnt", DW'(gnt), DW'(4'b0100));
      @(negedge clock);
      req = '0; reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("rstrd_rvalid_a", DW'(rvalid), '0);
      chk("rstrd_rdata", rdata[2*DW +: DW], '0);
      @(negedge clock); #1;
      chk("rstrd_rvalid_b", DW'(rvalid), '0);

      // Contention: all four read every cycle from rr=0
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         preload(16'h0040 + i, DW'(32'h1040 + i));
         set_port(i, AW'(16'h0040 + i), '0);
      end
      g[0] = 4'b0011; g[1] = 4'b1100; g[2] = 4'b0011; g[3] = 4'b1100;
      g[4] = 4'b0000; g[5] = 4'b0000;
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         req = (c < 4) ? 4'b1111 : 4'b0000; req_we = '0;
         #1;
         chk($sformatf("cont_gnt_c%0d", c), DW'(gnt), DW'(g[c]));
         if (c >= 2) chk($sformatf("cont_rvalid_c%0d", c), DW'(rvalid), DW'(g[c-2]));
      end
      chk("cont_rdata0", rdata[0 +: DW], DW'(32'h1040));
      chk("cont_rdata3", rdata[3*DW +: DW], DW'(32'h1043));

      // Clear with requester 1 holding a read of 0x05
      do_reset();
      for (int i = 0; i <= CD; i++) preload(i, DW'(32'h00F0 + i));
      @(negedge clock);
      req = 4'b0010; req_we = '0; set_port(1, 16'h0005, '0); clear_start = 1'b1;
      #1; chk("clr_start_gnt", DW'(gnt), '0);
      busy_cnt = 0; zero_cnt = 0; viol = 0;
      for (int c = 1; c < 40; c++) begin
         @(negedge clock);
         clear_start = (c == 5);
         #1;
         if (mem_we && mem_wbus == '0 && mem_waddr == AW'(zero_cnt)) zero_cnt++;
         if (busy) begin
            busy_cnt++;
            if (gnt[1]) viol++;
         end else if (busy_cnt > 0) begin
            break;
         end
      end
      clear_start = 1'b0;
      chk("clr_busy_cycles", DW'(busy_cnt), DW'(CD));
      chk("clr_zero_writes", DW'(zero_cnt), DW'(CD));
      chk("clr_gnt_blocked", DW'(viol), '0);
      chk("clr_gnt_after", DW'(gnt), DW'(4'b0010));
      @(negedge clock);
      req = '0;
      @(negedge clock); #1;
      chk("clr_rd_rvalid", DW'(rvalid), DW'(4'b0010));
      chk("clr_rd_rdata", rdata[DW +: DW], '0);
      chk("clr_mem15", mem[15], '0);
      chk("clr_mem16_kept", mem[16], DW'(32'h00F0 + 16));

      // Reset mid-clear at clr_addr=7
      do_reset();
      for (int i = 0; i < CD; i++) preload(i, DW'(32'h00C0 + i));
      @(negedge clock);
      clear_start = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clock);
         clear_start = 1'b0;
      end
      #1;
      chk("mid_waddr", DW'(mem_waddr), DW'(6));
      reset = 1'b1;
      @(negedge clock); #1;
      chk("mid_busy", DW'(busy), '0);
      chk("mid_mem_we", DW'(mem_we), '0);
      reset = 1'b0;
      @(negedge clock); #1;
      chk("mid_busy_after", DW'(busy), '0);
      chk("mid_mem_we_after", DW'(mem_we), '0);
      chk("mid_mem6", mem[6], '0);
      for (int i = 8; i < CD; i++)
         chk($sformatf("mid_mem%0d_kept", i), mem[i], DW'(32'h00C0 + i));

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Multi-requester front end for the 64K x 128-bit `memory` block: one write port and two read ports. Each cycle it arbitrates up to NREQ requesters round-robin, granting at most one write and two reads. All memory-side signals are registered, and read data is returned per requester with fixed latency. It also holds a zero-fill sequencer that clears a programmable number of words on command.

## Interface
- NREQ, 4, number of requesters (2..8)
- AW, 16, address width
- DW, 128, data width
- CLEAR_DEPTH, 65536, words zeroed by a clear (addresses 0..CLEAR_DEPTH-1)
- clock  in  1  single clock; all state on rising edge
- reset  in  1  synchronous, active-high
- req  in  NREQ  request valid, held until granted
- req_we  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*AW  per-requester address, requester i at [i*AW +: AW]
- req_wdata  in  NREQ*DW  per-requester write data
- gnt  out  NREQ  combinational accept; a transfer occurs when req&gnt at an edge
- rvalid  out  NREQ  one-cycle pulse, read data valid for requester i
- rdata  out  NREQ*DW  per-requester read data, held until next rvalid
- clear_start  in  1  pulse: begin zero-fill
- busy  out  1  high while clearing
- mem_we, mem_waddr, mem_wbus  out  1/AW/DW  to memory WE/WriteAddress/WriteBus
- mem_raddr1, mem_raddr2  out  AW  to memory ReadAddress1/2
- mem_rbus1, mem_rbus2  in  DW  from memory ReadBus1/2

## Operation
- FSM states: IDLE, CLEAR. Reset goes to IDLE.
- IDLE + clear_start goes to CLEAR with clr_addr=0. clear_start is ignored while in CLEAR.
- CLEAR: gnt=0. Each cycle registers mem_we=1, mem_waddr=clr_addr, mem_wbus=0, then clr_addr++. After the edge that issues address CLEAR_DEPTH-1, the FSM returns to IDLE.
- Arbitration (IDLE only): scan requesters in order rr, rr+1, ... mod NREQ.
  - The first write requester scanned gets the write port.
  - The first two read requesters scanned get port1 and port2, in scan order.
  - Other requesters get gnt=0.
- Pointer update: rr <= (index of the last granted requester in scan order)+1 mod NREQ. If nothing is granted, rr is unchanged.
- Accept edge:
  - mem_we/waddr/wbus are loaded from the write grant; mem_we=0 if there is no write grant.
  - mem_raddr1/2 are loaded from the read grants; an unused port keeps its old address.
  - Tag registers tag1/tag2 (requester index plus a valid bit) are loaded.
- Return edge (the next edge): for each valid tag, rdata[tag] <= mem_rbus, and rvalid[tag] pulses for one cycle.
- Port1 and port2 always go to distinct requesters, so there is no return collision.

## Timing
- gnt is combinational from req, req_we, rr and state.
- Write: accepted at edge E0; memory captures it at E1.
- Read: accepted at E0; address presented after E0; rdata captured and rvalid high in the cycle after E1, a latency of 2 edges.
- Hazard: a read and a write to the same address accepted at the same E0 return the old data. A read accepted at E1 or later returns the new data.
- Back-to-back: a requester may be granted on consecutive cycles, and reads pipeline at full rate.
- Reset (including mid-clear or mid-read):
  - State = IDLE, rr = 0, gnt = 0.
  - mem_we = 0, mem_waddr = 0, mem_wbus = 0, mem_raddr1/2 = 0.
  - tags invalid, rvalid = 0, rdata = 0, busy = 0.
  - In-flight reads are dropped.
- busy goes high the cycle after the clear_start edge and drops the cycle after the last clear write is issued.
- clear_start in the same cycle as requests: those requests get gnt=0 in that cycle, because clear wins.

## Structure
- Shared package `mem_pkg`:
  - AW and DW constants.
  - State enum {IDLE, CLEAR}.
  - Tag typedef (index plus valid).
- Sub-module `rr_pick`: given a request vector and a start pointer, returns the first and second set index in rotated order, plus found flags. It is instantiated twice: once for the write mask, once for the read mask.
- The FSM, registers and return path stay in `mem_arbiter`.

## Test plan
- Single read: NREQ=4, memory preloaded with word 0x10 = 0xA5..A5. Requester 2 reads 0x10 → gnt[2] at cycle 0, rvalid[2] at cycle 2, rdata[2] = 0xA5..A5.
- Write then read: requester 0 writes 0x20 = 0x1234 at cycle 0 and reads 0x20 at cycle 1 → rdata[0] = 0x1234. With the read also at cycle 0, rdata[0] = the old value.
- Contention: all 4 requesters issue reads every cycle from rr=0 → grants {0,1}, {2,3}, {0,1}, ...; each requester gets one rvalid every 2 cycles.
- Mixed ops: requesters 0 and 1 write, 2 and 3 read, rr=0 → cycle grants {0,2,3}, then {1,2,3}; rr ends at 0, then 0 again.
- Clear: CLEAR_DEPTH=16, clear_start with req[1]=1 held.
  - busy is high for 16 cycles and 16 zero writes go to 0..15.
  - gnt[1] stays 0 until busy falls, then reading 0x05 returns 0.
- Reset mid-clear at clr_addr=7 → busy=0 and mem_we=0 the next cycle; words 8..15 are untouched.
